// File: rtl/multi_decode_buffer_if.sv
// RV32 decode types and the fetch/decode/issue handshake bundle for multi_decode_buffer.
// master drives the fetch side and the consumer ready; slave is the decode buffer itself.
package rv32i_types;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc_curr;
        logic [31:0] pc_next;
        logic [31:0] immediate;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic        has_rd;
        alu_ops      alu_op;
        logic        alu_en;
        logic [2:0]  cmp_op;
        logic        cmp_en;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic        is_mul;
        logic [2:0]  mul_op;
        logic        is_signed;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
    } instruction_info_reg_t;

endpackage

interface multi_decode_buffer_if #(parameter int WIDTH = 2);
  import rv32i_types::*;

  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH*32-1:0]            in_inst;
  logic [WIDTH-1:0]               in_lane_valid;
  logic [31:0]                    in_pc;
  logic [WIDTH-1:0]               in_predict_taken;
  logic                           out_valid;
  logic                           out_ready;
  instruction_info_reg_t [WIDTH-1:0] out_info;
  logic [WIDTH-1:0]               out_lane_valid;

  modport master (
    output flush, in_valid, in_inst, in_lane_valid, in_pc, in_predict_taken, out_ready,
    input  in_ready, out_valid, out_info, out_lane_valid
  );

  modport slave (
    input  flush, in_valid, in_inst, in_lane_valid, in_pc, in_predict_taken, out_ready,
    output in_ready, out_valid, out_info, out_lane_valid
  );

endinterface

// File: rtl/multi_decode_buffer.sv
// N-wide RV32IM decode with taken-branch lane squash, feeding a DEPTH-group FIFO.
// Latency: one cycle (no fall-through); in_ready depends only on the occupancy count.
module multi_decode_buffer
  import rv32i_types::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multi_decode_buffer_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  function automatic alu_ops alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_sel = alt ? alu_sub : alu_add;
      3'b001:  alu_sel = alu_sll;
      3'b100:  alu_sel = alu_xor;
      3'b101:  alu_sel = alt ? alu_sra : alu_srl;
      3'b110:  alu_sel = alu_or;
      3'b111:  alu_sel = alu_and;
      default: alu_sel = alu_add;
    endcase
  endfunction

  function automatic instruction_info_reg_t decode(input logic [31:0] inst,
                                                   input logic [31:0] pc,
                                                   input logic        taken);
    instruction_info_reg_t d;
    logic [31:0] b_imm;
    d           = '0;
    b_imm       = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    d.valid     = 1'b1;
    d.inst      = inst;
    d.pc_curr   = pc;
    d.opcode    = inst[6:0];
    d.funct3    = inst[14:12];
    d.funct7    = inst[31:25];
    d.rs1_s     = inst[19:15];
    d.rs2_s     = inst[24:20];
    d.rd_s      = inst[11:7];
    d.has_rd    = 1'b1;
    d.alu_op    = alu_add;
    d.alu_en    = 1'b1;
    d.cmp_en    = 1'b1;
    case (inst[6:0])
      OP_LUI, OP_AUIPC: d.immediate = {inst[31:12], 12'b0};
      OP_JAL: begin
        d.immediate = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        d.is_jump   = 1'b1;
      end
      OP_JALR: begin
        d.immediate = {{21{inst[31]}}, inst[30:20]};
        d.is_jump   = 1'b1;
      end
      OP_BR: begin
        d.immediate = b_imm;
        d.is_branch = 1'b1;
        d.cmp_op    = inst[14:12];
        d.rd_s      = 5'd0;
        d.has_rd    = 1'b0;
      end
      OP_LOAD: begin
        d.immediate = {{21{inst[31]}}, inst[30:20]};
        d.rs2_s     = 5'd0;
        d.is_load   = 1'b1;
        d.is_signed = (inst[14:12] inside {3'b000, 3'b001, 3'b010});
        case (inst[14:12])
          3'b000, 3'b100: d.rmask = 4'h1;
          3'b001, 3'b101: d.rmask = 4'h3;
          3'b010:         d.rmask = 4'hF;
          default:        d.rmask = 4'h0;
        endcase
      end
      OP_STORE: begin
        d.immediate = {{21{inst[31]}}, inst[30:25], inst[11:7]};
        d.rd_s      = 5'd0;
        d.has_rd    = 1'b0;
        d.is_store  = 1'b1;
        case (inst[14:12])
          3'b000:  d.wmask = 4'h1;
          3'b001:  d.wmask = 4'h3;
          3'b010:  d.wmask = 4'hF;
          default: d.wmask = 4'h0;
        endcase
      end
      OP_IMM: begin
        d.immediate = {{21{inst[31]}}, inst[30:20]};
        d.rs2_s     = 5'd0;
        d.alu_op    = alu_sel(inst[14:12], (inst[14:12] == 3'b101) & inst[30]);
        d.cmp_op    = inst[12] ? 3'b110 : 3'b100;
      end
      OP_REG: begin
        if (inst[31:25] == 7'b0000001) begin
          d.is_mul    = 1'b1;
          d.mul_op    = inst[14:12];
          d.is_signed = (inst[14:12] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
        end else begin
          d.alu_op = alu_sel(inst[14:12], inst[30]);
          d.cmp_op = inst[12] ? 3'b110 : 3'b100;
        end
      end
      default: ;
    endcase
    // Predictions only redirect real branches; anything else falls through.
    d.pc_next = (taken && d.is_branch) ? pc + b_imm : pc + 32'd4;
    return d;
  endfunction

  instruction_info_reg_t [WIDTH-1:0] dec_info;
  logic [WIDTH-1:0]                  dec_lane_valid;
  logic                              blocked;

  always_comb begin
    dec_info       = '0;
    dec_lane_valid = '0;
    blocked        = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      dec_info[i]       = decode(bus.in_inst[32*i +: 32], bus.in_pc + 32'(4 * i),
                                 bus.in_predict_taken[i]);
      dec_lane_valid[i] = bus.in_lane_valid[i] & ~blocked;
      if (dec_lane_valid[i] & bus.in_predict_taken[i] & dec_info[i].is_branch)
        blocked = 1'b1;
    end
  end

  instruction_info_reg_t [WIDTH-1:0] mem_info [DEPTH];
  logic [WIDTH-1:0]                  mem_lane_valid [DEPTH];
  logic [PW-1:0]                     head;
  logic [PW-1:0]                     tail;
  logic [CW-1:0]                     count;
  logic                              enq;
  logic                              deq;

  assign bus.in_ready       = (count < CW'(DEPTH));
  assign bus.out_valid      = (count != '0);
  assign bus.out_info       = mem_info[head];
  assign bus.out_lane_valid = mem_lane_valid[head];

  // All-squashed groups are accepted but never occupy an entry.
  assign enq = bus.in_valid & bus.in_ready & ~bus.flush & (|dec_lane_valid);
  assign deq = bus.out_valid & bus.out_ready & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_info[i]       <= '0;
        mem_lane_valid[i] <= '0;
      end
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        mem_info[tail]       <= dec_info;
        mem_lane_valid[tail] <= dec_lane_valid;
        tail                 <= tail + PW'(1);
      end
      if (deq)
        head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
